// File: rtl/hasti_bram_bridge.sv
// AHB-lite (HASTI) slave that drives one port of a RAMB36-style block RAM.
// Reads are issued in the address phase; writes are registered and issued in the data phase.
module hasti_bram_bridge #(
    parameter int NWORDS     = 65536,
    parameter int ADDR_SHIFT = 5
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_di,
    output logic [3:0]  bram_dip,
    input  logic [31:0] bram_do
);

    localparam logic [1:0]  HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0]  HTRANS_SEQ    = 2'd3;
    localparam logic [31:0] NWORDS_LIM    = 32'(NWORDS);

    typedef enum logic [2:0] {IDLE, RD, WR, STALL, ERR1, ERR2} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [29:0] wr_idx;
    logic [3:0]  wr_be;
    logic        req;
    logic        illegal;
    logic        capture;
    logic [3:0]  be;

    function automatic logic [31:0] to_bram_addr(input logic [29:0] idx);
        return {2'b00, idx} << ADDR_SHIFT;
    endfunction

    assign req      = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign bram_dip = 4'b0000;

    always_comb begin
        illegal = (hsize > 3'd2)
               || (hsize == 3'd1 && haddr[0])
               || (hsize == 3'd2 && haddr[1:0] != 2'b00)
               || ({2'b00, haddr[31:2]} >= NWORDS_LIM);
        case (hsize)
            3'd0:    be = 4'b0001 << haddr[1:0];
            3'd1:    be = haddr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        hready    = 1'b1;
        hresp     = 1'b0;
        hrdata    = 32'h0;
        bram_en   = 1'b0;
        bram_we   = 4'b0000;
        bram_addr = 32'h0;
        bram_di   = 32'h0;
        state_nxt = IDLE;
        capture   = 1'b0;

        case (state)
            RD:   hrdata = bram_do;
            WR: begin
                bram_en   = 1'b1;
                bram_we   = wr_be;
                bram_addr = to_bram_addr(wr_idx);
                bram_di   = hwdata;
                // The port is busy with the write, so a legal read must wait one cycle.
                if (req && !hwrite && !illegal)
                    hready = 1'b0;
            end
            ERR1: begin
                hresp  = 1'b1;
                hready = 1'b0;
            end
            ERR2:    hresp = 1'b1;
            default: ;
        endcase

        if (req && hready) begin
            if (illegal) begin
                state_nxt = ERR1;
            end else if (hwrite) begin
                state_nxt = WR;
                capture   = 1'b1;
            end else begin
                state_nxt = RD;
                bram_en   = 1'b1;
                bram_we   = 4'b0000;
                bram_addr = to_bram_addr(haddr[31:2]);
            end
        end else if (state == ERR1) begin
            state_nxt = ERR2;
        end else if (state == WR && !hready) begin
            state_nxt = STALL;
        end

        // Hold everything quiet during reset so a pending write never reaches the RAM.
        if (!nreset) begin
            hready    = 1'b1;
            hresp     = 1'b0;
            hrdata    = 32'h0;
            bram_en   = 1'b0;
            bram_we   = 4'b0000;
            bram_addr = 32'h0;
            bram_di   = 32'h0;
            state_nxt = IDLE;
            capture   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state  <= IDLE;
            wr_idx <= 30'h0;
            wr_be  <= 4'b0000;
        end else begin
            state <= state_nxt;
            if (capture) begin
                wr_idx <= haddr[31:2];
                wr_be  <= be;
            end
        end
    end

endmodule
